uart_cmd_rx: RTL and testbench
==============================

# uart_cmd_rx

Host-to-board command path for the ADC capture board. The block deserialises 8N1 UART bytes arriving on the board RX pin, parses them into fixed 5-byte command frames, and drives capture control outputs: start pulse, calibration enable, and sample count. It is the receive-side counterpart of the capture/UART-TX dump path and runs in the `clk_50M` domain.

## Interface
- `BAUDRATE`, default 115200: line rate.
- `FREQ`, default 50_000_000: clock frequency in Hz. Bit period `BIT = FREQ/BAUDRATE` (integer division, 434). Half period `HALF = BIT/2` (217).
- `NUM_DEFAULT`, default 512: reset value of `num_samples`.
- `TIMEOUT_BYTES`, default 4: inter-byte timeout, in byte times. One byte time is `10*BIT` clocks.
- `clk_50M`, input, 1: single clock for the whole block.
- `nrst`, input, 1: asynchronous active-low reset.
- `rx2F`, input, 1: asynchronous serial input. Idles high.
- `rdata`, output, 8: last byte received correctly.
- `rvalid`, output, 1: 1-cycle pulse when `rdata` updates.
- `frame_err`, output, 1: 1-cycle pulse when a stop bit is sampled low.
- `cmd_valid`, output, 1: 1-cycle pulse when a frame is accepted.
- `cmd_err`, output, 1: 1-cycle pulse on bad header continuation, bad checksum, unknown opcode, zero count, frame error mid-frame, or timeout.
- `cmd_start`, output, 1: 1-cycle pulse on an accepted START frame.
- `calib_ena`, output, 1: registered calibration-enable level.
- `num_samples`, output, 16: registered sample count.

## Operation
- **Input synchroniser:** `rx2F` passes through 2 flip-flops (reset value 1), giving `rx_s`. All receiver logic uses `rx_s` only.
- **Receiver FSM:** states R_IDLE → R_START → R_DATA → R_STOP.
  - R_IDLE: a 1→0 transition on `rx_s` loads the bit counter to 0 and moves to R_START.
  - R_START: at count `HALF-1`, sample `rx_s`. If high, treat it as a glitch and return to R_IDLE with no output. If low, move to R_DATA.
  - R_DATA: sample 8 bits, LSB first, every `BIT` clocks after the start-bit centre.
  - R_STOP: sample the stop bit `BIT` clocks after bit 7.
    - Stop bit high: `rdata` ← shift register and `rvalid` pulses.
    - Stop bit low: `frame_err` pulses, the byte is dropped, and the FSM waits in R_STOP until `rx_s`=1 before returning to R_IDLE.
- **Frame format:** `0xA5`, OP, ARG_HI, ARG_LO, CHK, where CHK = OP ^ ARG_HI ^ ARG_LO.
- **Parser FSM:** states P_HDR → P_OP → P_HI → P_LO → P_CHK. It advances once per `rvalid`.
  - In P_HDR, any byte other than `0xA5` is silently discarded; no `cmd_err`.
  - A `0xA5` received in any later state is stored as data, not treated as a resync.
- **Opcodes**, executed on a matching CHK:
  - `0x01` START: `cmd_start` pulses. Args are ignored.
  - `0x02` CALIB: `calib_ena` ← ARG_LO[0].
  - `0x03` SETNUM: `num_samples` ← {ARG_HI, ARG_LO}. A value of 0 is rejected with `cmd_err` and the register is unchanged.
  - Any other opcode: `cmd_err`, no state change.
- **Result of a frame:** each frame ends in exactly one `cmd_valid` or one `cmd_err`, then the parser returns to P_HDR. A rejected frame changes no register.
- **Abort conditions** (parser not in P_HDR):
  - `frame_err` → `cmd_err` and return to P_HDR.
  - Timeout counter reaches `TIMEOUT_BYTES*10*BIT` clocks since the last `rvalid` → `cmd_err` and return to P_HDR. The counter is cleared on every `rvalid` and held at 0 in P_HDR.
- **Reset mid-operation:** all FSMs go to R_IDLE/P_HDR and outputs take their reset values. A byte in progress is lost; the next falling edge after reset release starts a new byte.

## Timing
- **Reset values:** `rdata`=0, `rvalid`=0, `frame_err`=0, `cmd_valid`=0, `cmd_err`=0, `cmd_start`=0, `calib_ena`=0, `num_samples`=`NUM_DEFAULT`.
- **Synchroniser latency:** 2 cycles from `rx2F` to `rx_s`.
- **Sample points:** let edge cycle E be the first cycle with `rx_s`=0.
  - Start-bit sample at E+HALF.
  - Data bit k (k = 0..7) at E+HALF+(k+1)·BIT.
  - Stop-bit sample at E+HALF+9·BIT.
- **Receiver outputs:** `rvalid` or `frame_err` is high the cycle after the stop-bit sample. The receiver is back in R_IDLE that same cycle, so back-to-back bytes with a single stop bit are received.
- **Parser outputs:** `cmd_valid`, `cmd_err`, and `cmd_start` are high the cycle after the `rvalid` of the CHK byte. `calib_ena` and `num_samples` update on that same edge.
- **Exclusivity:** `cmd_valid` and `cmd_err` are never high together. `cmd_start` is only high with `cmd_valid`.
- **Counter widths:** bit counter 16 bits; timeout counter 32 bits. Neither wraps; the timeout counter saturates at the abort point.

## Test plan
- **Reset and glitch:** apply reset, then hold `rx2F` low for 100 clocks and release → all outputs at reset values, `num_samples`=512, no `rvalid`.
- **Single byte:** send `0x55` at 115200 → exactly one `rvalid` with `rdata`=`0x55`, arriving 2+HALF+9·BIT+1 cycles after the start edge on `rx2F`; no `frame_err`.
- **Frame error recovery:** send `0x3C` with the stop bit forced low for one bit, then idle high, then send `0xC3` → one `frame_err`, no `rvalid` for `0x3C`, then `rvalid` with `rdata`=`0xC3`.
- **SETNUM and checksum:**
  - Frame `A5 03 04 00 07` → `cmd_valid` pulse, `num_samples`=1024.
  - Frame `A5 03 04 00 06` → `cmd_err`, `num_samples` stays 1024.
  - Frame `A5 03 00 00 03` → `cmd_err`, `num_samples` stays 1024.
- **START and CALIB with header resync:** send `FF 12 A5 01 00 00 01` → no error for `FF`/`12`, exactly one `cmd_start` with `cmd_valid`. Then `A5 02 00 01 03` → `calib_ena`=1.
- **Timeout and reset mid-frame:**
  - Send `A5 03`, then idle for `4·10·BIT` clocks → `cmd_err` pulse. A following `A5 02 00 01 03` is accepted.
  - Assert `nrst` during bit 4 of a byte → `calib_ena`=0, `num_samples`=512, and the next full frame is parsed correctly.

Source files
------------

// File: rtl/uart_cmd_rx.sv
// rtl/uart_cmd_rx.sv - 8N1 UART receiver with 5-byte command frame parser
// Drives capture start pulse, calibration enable and sample count from host frames.
module uart_cmd_rx #(
    parameter int BAUDRATE      = 115200,
    parameter int FREQ          = 50_000_000,
    parameter int NUM_DEFAULT   = 512,
    parameter int TIMEOUT_BYTES = 4
) (
    input  logic        clk_50M,
    input  logic        nrst,
    input  logic        rx2F,
    output logic [7:0]  rdata,
    output logic        rvalid,
    output logic        frame_err,
    output logic        cmd_valid,
    output logic        cmd_err,
    output logic        cmd_start,
    output logic        calib_ena,
    output logic [15:0] num_samples
);

    localparam int          BIT      = FREQ / BAUDRATE;
    localparam int          HALF     = BIT / 2;
    localparam logic [15:0] BIT_END  = 16'(BIT - 1);
    localparam logic [15:0] HALF_END = 16'(HALF - 1);
    localparam logic [31:0] TO_LIMIT = 32'(TIMEOUT_BYTES * 10 * BIT);
    localparam logic [15:0] NUM_RST  = 16'(NUM_DEFAULT);
    localparam logic [7:0]  HDR_BYTE = 8'hA5;

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [2:0] {P_HDR, P_OP, P_HI, P_LO, P_CHK} p_state_t;

    logic        r_rx_meta, r_rx_s, r_rx_prev;
    rx_state_t   r_rx_state, w_rx_next;
    logic [15:0] r_bit_cnt;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;
    logic        r_err_wait;
    logic [7:0]  r_rdata;
    logic        r_rvalid, r_frame_err;

    logic w_cnt_clr, w_shift_en, w_byte_ok, w_byte_bad, w_wait_set, w_wait_clr;

    always_ff @(posedge clk_50M or negedge nrst) begin
        if (!nrst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx2F;
            r_rx_s    <= r_rx_meta;
            r_rx_prev <= r_rx_s;
        end
    end

    always_ff @(posedge clk_50M or negedge nrst) begin
        if (!nrst) r_rx_state <= R_IDLE;
        else       r_rx_state <= w_rx_next;
    end

    always_comb begin
        w_rx_next  = r_rx_state;
        w_cnt_clr  = 1'b0;
        w_shift_en = 1'b0;
        w_byte_ok  = 1'b0;
        w_byte_bad = 1'b0;
        w_wait_set = 1'b0;
        w_wait_clr = 1'b0;
        case (r_rx_state)
            R_IDLE: begin
                if (!r_rx_s && r_rx_prev) begin
                    w_rx_next = R_START;
                    w_cnt_clr = 1'b1;
                end
            end
            R_START: begin
                if (r_bit_cnt == HALF_END) begin
                    w_cnt_clr = 1'b1;
                    w_rx_next = r_rx_s ? R_IDLE : R_DATA;
                end
            end
            R_DATA: begin
                if (r_bit_cnt == BIT_END) begin
                    w_cnt_clr  = 1'b1;
                    w_shift_en = 1'b1;
                    if (r_bit_idx == 3'd7) w_rx_next = R_STOP;
                end
            end
            R_STOP: begin
                // After a bad stop bit, hold here until the line returns high.
                if (r_err_wait) begin
                    if (r_rx_s) begin
                        w_rx_next  = R_IDLE;
                        w_wait_clr = 1'b1;
                    end
                end else if (r_bit_cnt == BIT_END) begin
                    if (r_rx_s) begin
                        w_byte_ok = 1'b1;
                        w_rx_next = R_IDLE;
                    end else begin
                        w_byte_bad = 1'b1;
                        w_wait_set = 1'b1;
                    end
                end
            end
            default: w_rx_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk_50M or negedge nrst) begin
        if (!nrst) begin
            r_bit_cnt   <= 16'd0;
            r_bit_idx   <= 3'd0;
            r_shift     <= 8'd0;
            r_err_wait  <= 1'b0;
            r_rdata     <= 8'd0;
            r_rvalid    <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_cnt_clr)                r_bit_cnt <= 16'd0;
            else if (r_bit_cnt != 16'hFFFF) r_bit_cnt <= r_bit_cnt + 16'd1;
            if (w_shift_en) begin
                r_shift   <= {r_rx_s, r_shift[7:1]};
                r_bit_idx <= r_bit_idx + 3'd1;
            end
            if (w_wait_set)      r_err_wait <= 1'b1;
            else if (w_wait_clr) r_err_wait <= 1'b0;
            if (w_byte_ok) r_rdata <= r_shift;
            r_rvalid    <= w_byte_ok;
            r_frame_err <= w_byte_bad;
        end
    end

    p_state_t    r_p_state, w_p_next;
    logic [7:0]  r_op, r_hi, r_lo;
    logic [31:0] r_to_cnt;
    logic        r_cmd_valid, r_cmd_err, r_cmd_start, r_calib;
    logic [15:0] r_num;

    logic w_ok, w_err, w_start, w_set_calib, w_set_num, w_ld_op, w_ld_hi, w_ld_lo;
    logic w_timeout;

    assign w_timeout = (r_to_cnt == TO_LIMIT);

    always_ff @(posedge clk_50M or negedge nrst) begin
        if (!nrst) r_p_state <= P_HDR;
        else       r_p_state <= w_p_next;
    end

    always_comb begin
        w_p_next    = r_p_state;
        w_ok        = 1'b0;
        w_err       = 1'b0;
        w_start     = 1'b0;
        w_set_calib = 1'b0;
        w_set_num   = 1'b0;
        w_ld_op     = 1'b0;
        w_ld_hi     = 1'b0;
        w_ld_lo     = 1'b0;
        if (r_p_state != P_HDR && (r_frame_err || w_timeout)) begin
            w_err    = 1'b1;
            w_p_next = P_HDR;
        end else if (r_rvalid) begin
            case (r_p_state)
                P_HDR: if (r_rdata == HDR_BYTE) w_p_next = P_OP;
                P_OP: begin
                    w_ld_op  = 1'b1;
                    w_p_next = P_HI;
                end
                P_HI: begin
                    w_ld_hi  = 1'b1;
                    w_p_next = P_LO;
                end
                P_LO: begin
                    w_ld_lo  = 1'b1;
                    w_p_next = P_CHK;
                end
                P_CHK: begin
                    w_p_next = P_HDR;
                    if (r_rdata != (r_op ^ r_hi ^ r_lo)) begin
                        w_err = 1'b1;
                    end else begin
                        case (r_op)
                            8'h01: begin
                                w_ok    = 1'b1;
                                w_start = 1'b1;
                            end
                            8'h02: begin
                                w_ok        = 1'b1;
                                w_set_calib = 1'b1;
                            end
                            8'h03: begin
                                if ({r_hi, r_lo} == 16'd0) begin
                                    w_err = 1'b1;
                                end else begin
                                    w_ok      = 1'b1;
                                    w_set_num = 1'b1;
                                end
                            end
                            default: w_err = 1'b1;
                        endcase
                    end
                end
                default: w_p_next = P_HDR;
            endcase
        end
    end

    always_ff @(posedge clk_50M or negedge nrst) begin
        if (!nrst) begin
            r_op        <= 8'd0;
            r_hi        <= 8'd0;
            r_lo        <= 8'd0;
            r_to_cnt    <= 32'd0;
            r_cmd_valid <= 1'b0;
            r_cmd_err   <= 1'b0;
            r_cmd_start <= 1'b0;
            r_calib     <= 1'b0;
            r_num       <= NUM_RST;
        end else begin
            if (w_ld_op) r_op <= r_rdata;
            if (w_ld_hi) r_hi <= r_rdata;
            if (w_ld_lo) r_lo <= r_rdata;
            // Inter-byte timer only runs while a frame is partially received.
            if (r_p_state == P_HDR || r_rvalid) r_to_cnt <= 32'd0;
            else if (!w_timeout)                r_to_cnt <= r_to_cnt + 32'd1;
            r_cmd_valid <= w_ok;
            r_cmd_err   <= w_err;
            r_cmd_start <= w_start;
            if (w_set_calib) r_calib <= r_lo[0];
            if (w_set_num)   r_num   <= {r_hi, r_lo};
        end
    end

    assign rdata       = r_rdata;
    assign rvalid      = r_rvalid;
    assign frame_err   = r_frame_err;
    assign cmd_valid   = r_cmd_valid;
    assign cmd_err     = r_cmd_err;
    assign cmd_start   = r_cmd_start;
    assign calib_ena   = r_calib;
    assign num_samples = r_num;

endmodule

// File: tb/tb_uart_cmd_rx.sv
// tb/tb_uart_cmd_rx.sv - self-checking bench for uart_cmd_rx
module tb_uart_cmd_rx;

    localparam int FREQ = 50_000_000;
    localparam int BAUD = 1_000_000;
    localparam int BIT  = FREQ / BAUD;
    localparam int HALF = BIT / 2;
    localparam int TO   = 4 * 10 * BIT;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        rx2F = 1'b1;
    logic [7:0]  rdata;
    logic        rvalid, frame_err, cmd_valid, cmd_err, cmd_start, calib_ena;
    logic [15:0] num_samples;

    uart_cmd_rx #(
        .BAUDRATE(BAUD), .FREQ(FREQ), .NUM_DEFAULT(512), .TIMEOUT_BYTES(4)
    ) dut (
        .clk_50M(clk), .nrst(nrst), .rx2F(rx2F), .rdata(rdata), .rvalid(rvalid),
        .frame_err(frame_err), .cmd_valid(cmd_valid), .cmd_err(cmd_err),
        .cmd_start(cmd_start), .calib_ena(calib_ena), .num_samples(num_samples)
    );

    always #10 clk = ~clk;

    typedef struct packed {
        logic ok;
        logic start;
    } exp_t;

    typedef struct packed {
        logic [39:0] frm;
        logic        ok;
        logic        start;
        logic        calib;
        logic [15:0] num;
    } vec_t;

    exp_t       cmd_q[$];
    logic [7:0] byte_q[$];

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    int t_start = 0;
    int last_rv_cyc = 0;
    int last_cmd_cyc = 0;
    int rv_cnt = 0;
    int fe_cnt = 0;
    int st_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (rvalid) begin
            rv_cnt++;
            last_rv_cyc = cyc;
            if (byte_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_rvalid: got rdata %0h expected no byte", rdata);
            end else begin
                check("rdata", 32'(rdata), 32'(byte_q.pop_front()));
            end
        end
        if (frame_err) fe_cnt++;
        if (cmd_start) st_cnt++;
        if (cmd_valid || cmd_err) begin
            last_cmd_cyc = cyc;
            if (cmd_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_cmd: got valid=%0b err=%0b expected none", cmd_valid, cmd_err);
            end else begin
                exp_t e;
                e = cmd_q.pop_front();
                check("cmd_valid", 32'(cmd_valid), 32'(e.ok));
                check("cmd_err", 32'(cmd_err), 32'(!e.ok));
                check("cmd_start", 32'(cmd_start), 32'(e.start));
            end
        end else if (cmd_start) begin
            n_total++;
            $display("FAIL stray_cmd_start: got 1 expected 0 without cmd_valid");
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx2F = 1'b0;
        t_start = cyc;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx2F = b[i];
            repeat (BIT) @(negedge clk);
        end
        rx2F = stop;
        repeat (BIT) @(negedge clk);
        rx2F = 1'b1;
        if (!stop) repeat (BIT) @(negedge clk);
    endtask

    task automatic send_good(input logic [7:0] b);
        byte_q.push_back(b);
        send_byte(b, 1'b1);
    endtask

    task automatic send_frame(input logic [39:0] f, input logic ok, input logic start);
        exp_t e;
        e.ok = ok;
        e.start = start;
        cmd_q.push_back(e);
        for (int i = 0; i < 5; i++) send_good(f[39-8*i -: 8]);
        repeat (4) @(negedge clk);
        check("frame_result_seen", 32'(cmd_q.size()), 32'd0);
    endtask

    initial begin
        #(20 * 200000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs[10];
        int   st0;
        int   d;
        exp_t te;
        vecs[0] = '{40'hA5_03_04_00_07, 1'b1, 1'b0, 1'b0, 16'd1024};
        vecs[1] = '{40'hA5_03_04_00_06, 1'b0, 1'b0, 1'b0, 16'd1024};
        vecs[2] = '{40'hA5_03_00_00_03, 1'b0, 1'b0, 1'b0, 16'd1024};
        vecs[3] = '{40'hA5_07_00_00_07, 1'b0, 1'b0, 1'b0, 16'd1024};
        vecs[4] = '{40'hA5_02_00_01_03, 1'b1, 1'b0, 1'b1, 16'd1024};
        vecs[5] = '{40'hA5_03_A5_01_A7, 1'b1, 1'b0, 1'b1, 16'hA501};
        vecs[6] = '{40'hA5_02_FF_FE_03, 1'b1, 1'b0, 1'b0, 16'hA501};
        vecs[7] = '{40'hA5_03_FF_FF_03, 1'b1, 1'b0, 1'b0, 16'hFFFF};
        vecs[8] = '{40'hA5_01_12_34_27, 1'b1, 1'b1, 1'b0, 16'hFFFF};
        vecs[9] = '{40'hA5_03_00_08_0B, 1'b1, 1'b0, 1'b0, 16'd8};

        repeat (5) @(negedge clk);
        check("rst_rdata", 32'(rdata), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check("rst_cmd_err", 32'(cmd_err), 32'd0);
        check("rst_cmd_start", 32'(cmd_start), 32'd0);
        check("rst_calib", 32'(calib_ena), 32'd0);
        check("rst_num", 32'(num_samples), 32'd512);
        nrst = 1'b1;
        repeat (5) @(negedge clk);

        rx2F = 1'b0;
        repeat (HALF / 2) @(negedge clk);
        rx2F = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        check("glitch_no_rvalid", 32'(rv_cnt), 32'd0);
        check("glitch_num", 32'(num_samples), 32'd512);

        send_good(8'h55);
        check("byte_latency", 32'(last_rv_cyc - t_start), 32'(2 + HALF + 9 * BIT + 1));
        check("byte_no_ferr", 32'(fe_cnt), 32'd0);

        send_byte(8'h3C, 1'b0);
        check("ferr_count", 32'(fe_cnt), 32'd1);
        send_good(8'hC3);
        check("ferr_recover", 32'(byte_q.size()), 32'd0);
        check("ferr_rv_count", 32'(rv_cnt), 32'd2);

        for (int i = 0; i < 10; i++) begin
            send_frame(vecs[i].frm, vecs[i].ok, vecs[i].start);
            check($sformatf("vec%0d_calib", i), 32'(calib_ena), 32'(vecs[i].calib));
            check($sformatf("vec%0d_num", i), 32'(num_samples), 32'(vecs[i].num));
        end

        st0 = st_cnt;
        send_good(8'hFF);
        send_good(8'h12);
        send_frame(40'hA5_01_00_00_01, 1'b1, 1'b1);
        check("resync_start_once", 32'(st_cnt - st0), 32'd1);
        send_frame(40'hA5_02_00_01_03, 1'b1, 1'b0);
        check("calib_set", 32'(calib_ena), 32'd1);

        te.ok = 1'b0;
        te.start = 1'b0;
        cmd_q.push_back(te);
        send_good(8'hA5);
        send_good(8'h03);
        for (int i = 0; i < 45 * BIT && cmd_q.size() != 0; i++) @(negedge clk);
        check("timeout_err", 32'(cmd_q.size()), 32'd0);
        d = last_cmd_cyc - last_rv_cyc;
        check("timeout_delay_window", 32'(d >= TO && d <= TO + 3), 32'd1);
        check("timeout_num_kept", 32'(num_samples), 32'd8);
        send_frame(40'hA5_02_00_00_02, 1'b1, 1'b0);
        send_frame(40'hA5_02_00_01_03, 1'b1, 1'b0);
        check("post_timeout_calib", 32'(calib_ena), 32'd1);

        rx2F = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx2F = i[0];
            repeat (BIT) @(negedge clk);
        end
        rx2F = 1'b1;
        repeat (BIT / 2) @(negedge clk);
        nrst = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_rdata", 32'(rdata), 32'd0);
        check("midrst_calib", 32'(calib_ena), 32'd0);
        check("midrst_num", 32'(num_samples), 32'd512);
        rx2F = 1'b1;
        nrst = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        send_frame(40'hA5_03_00_08_0B, 1'b1, 1'b0);
        check("after_rst_num", 32'(num_samples), 32'd8);

        repeat (10) @(negedge clk);
        check("cmd_q_empty", 32'(cmd_q.size()), 32'd0);
        check("byte_q_empty", 32'(byte_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
